object_engine: RTL
==================

OBJECT_ENGINE -- requirements
Module: object_engine

Interface
REQ-001 Parameter NUM_OBJECTS, default 5: number of movable objects (players/missiles/ball); legal range 2..8.
REQ-002 Parameter POS_WIDTH, default 10: width of hpos and of each object's X position.
REQ-003 Parameter H_MAX, default 858: line length in pixels; positions wrap modulo H_MAX.
REQ-004 Port raw_clk  in  1: the single clock; all state is on its rising edge.
REQ-005 Port reset  in  1: asynchronous, active-high reset.
REQ-006 Port write_enable  in  1: register write strobe, one cycle per write.
REQ-007 Port enable  in  1: register read strobe.
REQ-008 Port address  in  6: register address.
REQ-009 Port data_in  in  8: write data.
REQ-010 Port data_out  out  8: read data.
REQ-011 Port hpos  in  POS_WIDTH: current pixel column.
REQ-012 Port line_start  in  1: one-cycle pulse at the start of each line.
REQ-013 Port obj_value  out  NUM_OBJECTS: per-object pixel-on flags for the colour priority mux.

Function
REQ-014 Per-object registers, base i*4: +0 graphics[7:0]; +1 posx[7:0]; +2 {width[5:4], reflect[3], enable[2], posx[POS_WIDTH-1:8] in [1:0]}; +3 motion[7:4], signed 4-bit.
REQ-015 width: 0 = 1 px/bit, 1 = 2 px/bit, 2 = 4 px/bit, 3 = 8 px/bit; object span = 8 << width pixels.
REQ-016 Strobe condition: hpos == posx and enable = 1; the object starts emitting on the next cycle.
REQ-017 Emission order: graphics bit 7 first when reflect = 0, bit 0 first when reflect = 1; obj_value[i] is the current bit for the whole span, then 0.
REQ-018 A strobe during an active span restarts the span from its first bit.
REQ-019 posx >= H_MAX never strobes.
REQ-020 Graphics, width and reflect are sampled at strobe; writes during a span affect only the next span.
REQ-021 Address 0x20 write arms HMOVE; on the next line_start each posx becomes (posx + sign_extend(motion)) mod H_MAX, then HMOVE disarms.
REQ-022 Address 0x21 write clears all motion fields to 0.
REQ-023 A same-cycle CPU write to posx and an HMOVE update: the CPU write wins.
REQ-024 Read latency is 1 cycle: data_out is updated the cycle after enable is high; data_out holds otherwise.
REQ-025 Unmapped read addresses return 0x00; unmapped writes are ignored.

Reset
REQ-026 Reset clears all registers, spans, the HMOVE arm and the collision latches; obj_value = 0 and data_out = 0x00.
REQ-027 Reset asserted mid-span drops obj_value to 0 immediately (asynchronous).

Configuration
REQ-028 Macro OBJECT_ENGINE_COLLISION_EN selects collision logic. When defined:
- One sticky latch per unordered object pair, NUM_OBJECTS*(NUM_OBJECTS-1)/2 latches, packed pair-major, (0,1) at bit 0.
- A latch sets on any cycle in which both obj_value bits of its pair are 1.
- Latches are read at 0x28..0x2B, 8 bits per address, unused bits 0.
- A write to 0x22 clears all latches; a set on the same cycle as the clear wins.
REQ-029 Without OBJECT_ENGINE_COLLISION_EN: no collision logic, 0x28..0x2B read 0x00, and writes to 0x22 are ignored.

Structure
REQ-030 Package object_engine_pkg holds:
- register offset and address constants (0x20, 0x21, 0x22, 0x28);
- the width enum;
- a pair-index function for collision bit packing.
REQ-031 One sub-module, object_shifter, is instantiated NUM_OBJECTS times and handles strobe, span counting, reflection and pixel output; object_engine holds the register file, HMOVE and collision logic.

Verification
REQ-032 Object 0 set with posx = 100, graphics = 0x81, width = 0, enable = 1 -> obj_value[0] is high at the cycles following hpos 100 and 107 only.
REQ-033 Same object with width = 2 and reflect = 1, graphics = 0x01 -> obj_value[0] is high for the first 4 pixels of a 32-pixel span.
REQ-034 posx = 5, motion = -8, write 0x20, then pulse line_start -> posx reads back H_MAX-3 (855), and a second line_start makes no change.
REQ-035 Objects 0 and 1 overlap at posx = 200 with COLLISION_EN defined -> 0x28 bit 0 = 1 after the line; write 0x22 -> reads 0x00; without the macro it always reads 0x00.
REQ-036 Reset asserted mid-span -> obj_value = 0 within the same cycle; after release there is no output until a new strobe.

Source files
------------

// File: rtl/object_engine_pkg.sv
// Shared constants, types and helpers for the object engine register map.
// The optional collision logic is selected with the OBJECT_ENGINE_COLLISION_EN macro.
package object_engine_pkg;

  localparam logic [1:0] OFF_GRAPHICS = 2'd0;
  localparam logic [1:0] OFF_POSX_LO  = 2'd1;
  localparam logic [1:0] OFF_CTRL     = 2'd2;
  localparam logic [1:0] OFF_MOTION   = 2'd3;

  localparam logic [5:0] ADDR_HMOVE     = 6'h20;
  localparam logic [5:0] ADDR_HMCLR     = 6'h21;
  localparam logic [5:0] ADDR_COLL_CLR  = 6'h22;
  localparam logic [5:0] ADDR_COLL_BASE = 6'h28;

  typedef enum logic [1:0] {
    WIDTH_1X = 2'd0,
    WIDTH_2X = 2'd1,
    WIDTH_4X = 2'd2,
    WIDTH_8X = 2'd3
  } width_e;

  typedef enum logic {
    SH_IDLE = 1'b0,
    SH_EMIT = 1'b1
  } shifter_state_e;

  // Pair-major packing: (0,1),(0,2)..(0,n-1),(1,2).. so (0,1) lands on bit 0.
  function automatic int pair_index(input int a, input int b, input int n);
    return (a * (2 * n - a - 1)) / 2 + (b - a - 1);
  endfunction

endpackage

// File: rtl/object_shifter.sv
// One movable object: detects its strobe, walks the scaled 8-bit span and
// emits the selected graphics bit each pixel.
module object_shifter
  import object_engine_pkg::*;
#(
  parameter int POS_WIDTH = 10,
  parameter int H_MAX     = 858
) (
  input  logic                 raw_clk,
  input  logic                 reset,
  input  logic [POS_WIDTH-1:0] hpos,
  input  logic [POS_WIDTH-1:0] posx,
  input  logic                 enable,
  input  logic [7:0]           graphics,
  input  width_e               width,
  input  logic                 reflect,
  output logic                 pixel
);

  shifter_state_e state_q, state_n;
  logic [5:0]     cnt_q, cnt_n;
  logic [7:0]     gfx_q, gfx_n;
  width_e         width_q, width_n;
  logic           reflect_q, reflect_n;

  logic           strobe;
  logic [5:0]     span_last;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_sel;

  assign strobe = enable && (hpos == posx) && (int'(posx) < H_MAX);

  always_comb begin
    span_last = 6'd7;
    bit_idx   = cnt_q[2:0];
    case (width_q)
      WIDTH_1X: begin span_last = 6'd7;  bit_idx = cnt_q[2:0]; end
      WIDTH_2X: begin span_last = 6'd15; bit_idx = cnt_q[3:1]; end
      WIDTH_4X: begin span_last = 6'd31; bit_idx = cnt_q[4:2]; end
      WIDTH_8X: begin span_last = 6'd63; bit_idx = cnt_q[5:3]; end
      default:  begin span_last = 6'd7;  bit_idx = cnt_q[2:0]; end
    endcase
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state_q   <= SH_IDLE;
      cnt_q     <= '0;
      gfx_q     <= '0;
      width_q   <= WIDTH_1X;
      reflect_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      gfx_q     <= gfx_n;
      width_q   <= width_n;
      reflect_q <= reflect_n;
    end
  end

  // A strobe always (re)starts the span and captures the look of the object.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    gfx_n     = gfx_q;
    width_n   = width_q;
    reflect_n = reflect_q;
    if (strobe) begin
      state_n   = SH_EMIT;
      cnt_n     = '0;
      gfx_n     = graphics;
      width_n   = width;
      reflect_n = reflect;
    end else if (state_q == SH_EMIT) begin
      if (cnt_q == span_last) begin
        state_n = SH_IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    bit_sel = reflect_q ? bit_idx : (3'd7 - bit_idx);
    pixel   = 1'b0;
    if (state_q == SH_EMIT) begin
      pixel = gfx_q[bit_sel];
    end
  end

endmodule

// File: rtl/object_engine.sv
// Object engine top: CPU register file, HMOVE position update, optional pairwise
// collision latches (OBJECT_ENGINE_COLLISION_EN) and one shifter per object.
module object_engine
  import object_engine_pkg::*;
#(
  parameter int NUM_OBJECTS = 5,
  parameter int POS_WIDTH   = 10,
  parameter int H_MAX       = 858
) (
  input  logic                   raw_clk,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic                   enable,
  input  logic [5:0]             address,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic [POS_WIDTH-1:0]   hpos,
  input  logic                   line_start,
  output logic [NUM_OBJECTS-1:0] obj_value
);

  logic [7:0]           graphics_q [NUM_OBJECTS];
  logic [POS_WIDTH-1:0] posx_q     [NUM_OBJECTS];
  width_e               width_q    [NUM_OBJECTS];
  logic                 reflect_q  [NUM_OBJECTS];
  logic                 en_q       [NUM_OBJECTS];
  logic [3:0]           motion_q   [NUM_OBJECTS];

  logic                   hmove_armed;
  logic                   hmove_go;
  logic                   motion_clear;
  logic                   addr_is_obj;
  logic [2:0]             addr_obj;
  logic [1:0]             addr_off;
  logic [NUM_OBJECTS-1:0] obj_wr;
  logic [NUM_OBJECTS-1:0] posx_wr;
  logic [7:0]             rd_data;

  assign addr_obj     = address[4:2];
  assign addr_off     = address[1:0];
  assign addr_is_obj  = !address[5] && (int'(addr_obj) < NUM_OBJECTS);
  assign hmove_go     = line_start && hmove_armed;
  assign motion_clear = write_enable && (address == ADDR_HMCLR);

  function automatic logic [POS_WIDTH-1:0] wrap_add(input logic [POS_WIDTH-1:0] p,
                                                     input logic [3:0] m);
    int sum;
    sum = int'(p) + int'($signed(m));
    if (sum < 0) begin
      sum = sum + H_MAX;
    end else if (sum >= H_MAX) begin
      sum = sum - H_MAX;
    end
    return POS_WIDTH'(sum);
  endfunction

  always_comb begin
    obj_wr  = '0;
    posx_wr = '0;
    for (int i = 0; i < NUM_OBJECTS; i++) begin
      obj_wr[i]  = write_enable && addr_is_obj && (addr_obj == 3'(i));
      posx_wr[i] = obj_wr[i] && ((addr_off == OFF_POSX_LO) || (addr_off == OFF_CTRL));
    end
  end

  // An object whose position is being written this cycle skips the HMOVE step.
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      hmove_armed <= 1'b0;
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        graphics_q[i] <= '0;
        posx_q[i]     <= '0;
        width_q[i]    <= WIDTH_1X;
        reflect_q[i]  <= 1'b0;
        en_q[i]       <= 1'b0;
        motion_q[i]   <= '0;
      end
    end else begin
      if (hmove_go) begin
        hmove_armed <= 1'b0;
      end
      if (write_enable && (address == ADDR_HMOVE)) begin
        hmove_armed <= 1'b1;
      end
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        if (hmove_go && !posx_wr[i]) begin
          posx_q[i] <= wrap_add(posx_q[i], motion_q[i]);
        end
        if (motion_clear) begin
          motion_q[i] <= '0;
        end
        if (obj_wr[i]) begin
          case (addr_off)
            OFF_GRAPHICS: graphics_q[i] <= data_in;
            OFF_POSX_LO:  posx_q[i][7:0] <= data_in;
            OFF_CTRL: begin
              width_q[i]                  <= width_e'(data_in[5:4]);
              reflect_q[i]                <= data_in[3];
              en_q[i]                     <= data_in[2];
              posx_q[i][POS_WIDTH-1:8]    <= data_in[POS_WIDTH-9:0];
            end
            OFF_MOTION:   motion_q[i] <= data_in[7:4];
            default: ;
          endcase
        end
      end
    end
  end

`ifdef OBJECT_ENGINE_COLLISION_EN
  localparam int NUM_PAIRS = NUM_OBJECTS * (NUM_OBJECTS - 1) / 2;

  logic [NUM_PAIRS-1:0] coll_q;
  logic [NUM_PAIRS-1:0] coll_hit;
  logic [31:0]          coll_padded;
  logic                 coll_clear;

  for (genvar ga = 0; ga < NUM_OBJECTS; ga++) begin : g_coll_a
    for (genvar gb = ga + 1; gb < NUM_OBJECTS; gb++) begin : g_coll_b
      assign coll_hit[pair_index(ga, gb, NUM_OBJECTS)] = obj_value[ga] & obj_value[gb];
    end
  end

  assign coll_clear  = write_enable && (address == ADDR_COLL_CLR);
  assign coll_padded = 32'(coll_q);

  // A hit in the clearing cycle still survives the clear.
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      coll_q <= '0;
    end else if (coll_clear) begin
      coll_q <= coll_hit;
    end else begin
      coll_q <= coll_q | coll_hit;
    end
  end
`endif

  always_comb begin
    rd_data = 8'h00;
    if (addr_is_obj) begin
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        if (addr_obj == 3'(i)) begin
          case (addr_off)
            OFF_GRAPHICS: rd_data = graphics_q[i];
            OFF_POSX_LO:  rd_data = posx_q[i][7:0];
            OFF_CTRL: begin
              rd_data = {2'b00, width_q[i], reflect_q[i], en_q[i], 2'b00};
              rd_data[POS_WIDTH-9:0] = posx_q[i][POS_WIDTH-1:8];
            end
            OFF_MOTION:   rd_data = {motion_q[i], 4'h0};
            default:      rd_data = 8'h00;
          endcase
        end
      end
    end
`ifdef OBJECT_ENGINE_COLLISION_EN
    if (address[5:2] == ADDR_COLL_BASE[5:2]) begin
      rd_data = coll_padded[address[1:0]*8 +: 8];
    end
`endif
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      data_out <= 8'h00;
    end else if (enable) begin
      data_out <= rd_data;
    end
  end

  for (genvar gi = 0; gi < NUM_OBJECTS; gi++) begin : g_obj
    object_shifter #(
      .POS_WIDTH (POS_WIDTH),
      .H_MAX     (H_MAX)
    ) u_shifter (
      .raw_clk  (raw_clk),
      .reset    (reset),
      .hpos     (hpos),
      .posx     (posx_q[gi]),
      .enable   (en_q[gi]),
      .graphics (graphics_q[gi]),
      .width    (width_q[gi]),
      .reflect  (reflect_q[gi]),
      .pixel    (obj_value[gi])
    );
  end

endmodule
